hazard_scoreboard: RTL and testbench

//   Parametrised successor to the ID-stage stall logic: a per-register countdown scoreboard.

---
 rtl/hazard_scoreboard.sv | 120 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard for ID-stage RAW/WAW/stack stall detection with flush recovery.
// Optional macro HAZARD_SCOREBOARD_FWD_EN lets forwardable results satisfy RAW one cycle early.
module hazard_scoreboard #(
  parameter int NREG      = 4,
  parameter int REG_W     = 2,
  parameter int CW        = 2,
  parameter int STACK_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_src_a_used,
  input  logic [REG_W-1:0] id_src_a,
  input  logic             id_src_b_used,
  input  logic [REG_W-1:0] id_src_b,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic [CW-1:0]    id_wr_lat,
  input  logic             id_wr_fwd,
  input  logic             id_is_stack,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       hazard_cause,
  output logic [NREG-1:0]  busy_mask,
  output logic [15:0]      stall_count
);

  localparam int SW = $clog2(STACK_LAT + 1);

  logic [CW-1:0]    cnt_q [NREG];
  logic [CW-1:0]    cnt_d [NREG];
  logic [NREG-1:0]  fwd_q, fwd_d;
  logic [SW-1:0]    stk_q, stk_d;
  logic             rec_v_q, rec_v_d;
  logic [REG_W-1:0] rec_reg_q, rec_reg_d;
  logic [CW-1:0]    rec_p_q, rec_p_d;
  logic [15:0]      sc_q, sc_d;

  logic            active, raw, waw, stk_haz, stall_int, issue;
  logic [CW-1:0]   thr_a, thr_b;
  logic [NREG-1:0] busy;

  // Forwardable entries are readable via EX/MEM one cycle before their write.
`ifdef HAZARD_SCOREBOARD_FWD_EN
  assign thr_a = {{(CW-1){1'b0}}, fwd_q[id_src_a]};
  assign thr_b = {{(CW-1){1'b0}}, fwd_q[id_src_b]};
`else
  logic fwd_unused;
  assign fwd_unused = ^fwd_q;
  assign thr_a = '0;
  assign thr_b = '0;
`endif

  always_comb begin
    for (int r = 0; r < NREG; r++) busy[r] = (cnt_q[r] != '0);
    active    = id_valid & ~flush;
    raw       = (id_src_a_used & (cnt_q[id_src_a] > thr_a)) |
                (id_src_b_used & (cnt_q[id_src_b] > thr_b));
    waw       = id_wr_en & (cnt_q[id_wr_reg] > id_wr_lat);
    stk_haz   = id_is_stack & (stk_q != '0);
    stall_int = active & (raw | waw | stk_haz);
    issue     = active & ~stall_int;

    stall        = stall_int;
    hazard_cause = 2'b00;
    if (active) begin
      if (raw)          hazard_cause = 2'b01;
      else if (waw)     hazard_cause = 2'b10;
      else if (stk_haz) hazard_cause = 2'b11;
    end
    busy_mask   = active ? busy : '0;
    stall_count = active ? sc_q : 16'h0000;
  end

  always_comb begin
    fwd_d     = fwd_q;
    stk_d     = (stk_q != '0) ? stk_q - SW'(1) : stk_q;
    rec_v_d   = issue & id_wr_en;
    rec_reg_d = rec_reg_q;
    rec_p_d   = rec_p_q;
    sc_d      = (stall_int && sc_q != 16'hFFFF) ? sc_q + 16'd1 : sc_q;
    for (int r = 0; r < NREG; r++)
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : cnt_q[r];

    // Squashed writer: hand the entry back to the older writer's timeline.
    if (flush && rec_v_q) begin
      cnt_d[rec_reg_q] = (rec_p_q > CW'(1)) ? rec_p_q - CW'(2) : '0;
      fwd_d[rec_reg_q] = 1'b0;
    end

    if (issue && id_wr_en) begin
      rec_reg_d        = id_wr_reg;
      rec_p_d          = cnt_q[id_wr_reg];
      cnt_d[id_wr_reg] = id_wr_lat;
      fwd_d[id_wr_reg] = id_wr_fwd;
    end
    if (issue && id_is_stack) stk_d = SW'(STACK_LAT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      fwd_q     <= '0;
      stk_q     <= '0;
      rec_v_q   <= 1'b0;
      rec_reg_q <= '0;
      rec_p_q   <= '0;
      sc_q      <= 16'h0000;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      fwd_q     <= fwd_d;
      stk_q     <= stk_d;
      rec_v_q   <= rec_v_d;
      rec_reg_q <= rec_reg_d;
      rec_p_q   <= rec_p_d;
      sc_q      <= sc_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random traffic against a
// model that tracks absolute ready times per register instead of countdowns.
module tb_hazard_scoreboard;
  localparam int NREG = 4, REG_W = 2, CW = 2, STACK_LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, id_valid, id_src_a_used, id_src_b_used, id_wr_en, id_wr_fwd;
  logic             id_is_stack, flush;
  logic [REG_W-1:0] id_src_a, id_src_b, id_wr_reg;
  logic [CW-1:0]    id_wr_lat;
  logic             stall;
  logic [1:0]       hazard_cause;
  logic [NREG-1:0]  busy_mask;
  logic [15:0]      stall_count;

  hazard_scoreboard #(.NREG(NREG), .REG_W(REG_W), .CW(CW), .STACK_LAT(STACK_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_src_a_used(id_src_a_used), .id_src_a(id_src_a),
    .id_src_b_used(id_src_b_used), .id_src_b(id_src_b),
    .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_wr_lat(id_wr_lat), .id_wr_fwd(id_wr_fwd),
    .id_is_stack(id_is_stack), .flush(flush),
    .stall(stall), .hazard_cause(hazard_cause), .busy_mask(busy_mask), .stall_count(stall_count)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: each register becomes readable at absolute cycle ready[r].
  longint now;
  longint ready [NREG];
  bit     fwdm  [NREG];
  longint stk_ready, rec_prev;
  bit     rec_v;
  int     rec_reg;
  int     sc;

  function automatic int mcnt(int r);
    return (ready[r] > now) ? int'(ready[r] - now) : 0;
  endfunction

  function automatic int thr(int r);
`ifdef HAZARD_SCOREBOARD_FWD_EN
    return fwdm[r] ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) begin ready[r] = 0; fwdm[r] = 0; end
    stk_ready = 0; rec_v = 0; rec_reg = 0; rec_prev = 0; sc = 0;
  endtask

  // One clock with the inputs currently driven; returns the model's stall decision.
  task automatic step(output bit e_stall);
    bit act, raw, waw, stkh, iss;
    logic [1:0] e_cause;
    logic [NREG-1:0] e_busy;
    int wr;
    #1;
    wr   = int'(id_wr_reg);
    act  = id_valid && !flush;
    raw  = (id_src_a_used && mcnt(int'(id_src_a)) > thr(int'(id_src_a))) ||
           (id_src_b_used && mcnt(int'(id_src_b)) > thr(int'(id_src_b)));
    waw  = id_wr_en && mcnt(wr) > int'(id_wr_lat);
    stkh = id_is_stack && stk_ready > now;
    e_stall = act && (raw || waw || stkh);
    e_cause = !act ? 2'b00 : raw ? 2'b01 : waw ? 2'b10 : stkh ? 2'b11 : 2'b00;
    e_busy  = '0;
    for (int r = 0; r < NREG; r++) if (act && mcnt(r) > 0) e_busy[r] = 1'b1;
    if (rst_n) begin
      chk("stall", 32'(stall), 32'(e_stall));
      chk("hazard_cause", 32'(hazard_cause), 32'(e_cause));
      chk("busy_mask", 32'(busy_mask), 32'(e_busy));
      chk("stall_count", 32'(stall_count), act ? 32'(sc) : 32'd0);
    end
    @(posedge clk);
    if (!rst_n) model_clear();
    else begin
      iss = id_valid && !e_stall && !flush;
      if (flush && rec_v) begin ready[rec_reg] = rec_prev; fwdm[rec_reg] = 0; end
      if (iss && id_wr_en) begin
        rec_prev = ready[wr]; rec_reg = wr;
        ready[wr] = now + 1 + longint'(id_wr_lat); fwdm[wr] = id_wr_fwd;
      end
      if (iss && id_is_stack) stk_ready = now + 1 + STACK_LAT;
      rec_v = iss && id_wr_en;
      if (e_stall && sc < 65535) sc++;
    end
    now++;
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input bit au, input int a, input bit bu, input int b,
                       input bit we, input int wr, input int lat, input bit fw,
                       input bit st, input bit fl);
    id_valid = v; id_src_a_used = au; id_src_a = REG_W'(a); id_src_b_used = bu;
    id_src_b = REG_W'(b); id_wr_en = we; id_wr_reg = REG_W'(wr); id_wr_lat = CW'(lat);
    id_wr_fwd = fw; id_is_stack = st; flush = fl;
  endtask

  // Hold an instruction in ID until it issues, bounded.
  task automatic run(input bit au, input int a, input bit bu, input int b, input bit we,
                     input int wr, input int lat, input bit fw, input bit st);
    bit s;
    bit done = 0;
    for (int k = 0; k < 8 && !done; k++) begin
      drive(1, au, a, bu, b, we, wr, lat, fw, st, 0);
      step(s);
      if (!s) done = 1;
    end
    if (!done) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    bit s;
    for (int k = 0; k < n; k++) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(s); end
  endtask

  initial begin
    bit s;
    now = 0;
    model_clear();
    rst_n = 1'b0;
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_cause", 32'(hazard_cause), 32'd0);
    chk("reset_busy", 32'(busy_mask), 32'd0);
    chk("reset_count", 32'(stall_count), 32'd0);
    rst_n = 1'b1;

    // ALU producer then consumer
    run(1, 1, 0, 0, 1, 0, 2, 1, 0);
    run(1, 0, 0, 0, 1, 2, 1, 1, 0);
    idle(4);
    // load producer then consumer
    run(0, 0, 0, 0, 1, 1, 3, 0, 0);
    run(1, 1, 1, 2, 1, 3, 1, 1, 0);
    idle(4);
    // WAW ordering
    run(0, 0, 0, 0, 1, 2, 3, 0, 0);
    run(0, 0, 0, 0, 1, 2, 1, 1, 0);
    idle(4);
    // back-to-back stack ops
    run(0, 0, 0, 0, 0, 0, 0, 0, 1);
    run(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(4);
    // flush of a freshly issued load, then a read of its destination
    run(0, 0, 0, 0, 1, 1, 3, 0, 0);
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1); step(s);
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0); step(s);
    chk("flush_busy_r1", 32'(busy_mask[1]), 32'd0);
    run(1, 1, 0, 0, 0, 0, 0, 0, 0);
    // flush restoring an older in-flight writer
    run(0, 0, 0, 0, 1, 0, 3, 1, 0);
    run(0, 0, 0, 0, 1, 0, 3, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1); step(s);
    run(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    for (int i = 0; i < 600; i++) begin
      bit we = ($urandom_range(0, 3) != 0);
      rst_n = (i == 300) ? 1'b0 : 1'b1;
      drive($urandom_range(0, 9) != 0,
            $urandom_range(0, 1), $urandom_range(0, NREG - 1),
            $urandom_range(0, 1), $urandom_range(0, NREG - 1),
            we, $urandom_range(0, NREG - 1), we ? $urandom_range(1, 3) : $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
      step(s);
    end
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
